// File: rtl/da_mem_pkg.sv
// Shared widths and the arbiter grant encoding for the sample-memory ring controller.
package da_mem_pkg;
   localparam int MEM_ADDR_WIDTH = 23;
   localparam int MEM_DATA_WIDTH = 16;

   typedef enum logic {
      GRANT_READ  = 1'b0,
      GRANT_WRITE = 1'b1
   } grant_e;
endpackage

// File: rtl/bram_8m_16.sv
// Behavioural single-port sample memory: synchronous read, one-cycle latency, data driven only while oe.
module bram_8m_16 #(
   parameter int AW = 23,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic          oe,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] rd_q;

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) rd_q <= '0;
      else       rd_q <= mem[addr];
   end

   // Bus reads as zero when not enabled.
   assign dout = oe ? rd_q : '0;
endmodule

// File: rtl/bram_ring_skid.sv
// Two-entry output skid FIFO absorbing the memory read latency; head is presented to the consumer.
module bram_ring_skid #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] head_data,
   output logic          head_valid,
   output logic [1:0]    count
);
   logic [1:0][DW-1:0] ent_q, ent_d;
   logic               rd_ptr_q, rd_ptr_d;
   logic               wr_ptr_q, wr_ptr_d;
   logic [1:0]         count_q, count_d;
   logic               pop_ok;

   assign pop_ok     = pop & (count_q != 2'd0);
   assign head_valid = (count_q != 2'd0);
   assign head_data  = head_valid ? ent_q[rd_ptr_q] : '0;
   assign count      = count_q;

   always_comb begin
      ent_d    = ent_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q + 2'(push) - 2'(pop_ok);
      if (push) begin
         ent_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_d = ~rd_ptr_q;
      if (flush) begin
         ent_d    = '0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ent_q    <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         ent_q    <= ent_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/bram_ring_ctrl.sv
// Circular sample buffer over a single-port synchronous memory: write/read arbitration,
// pointer management and read-latency absorption via the skid FIFO.
module bram_ring_ctrl
   import da_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
   parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH:0]   fill_count,
   output logic                  empty,
   output logic                  full,
   output logic                  mem_we,
   output logic                  mem_oe,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout
);
   localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [ADDR_WIDTH:0] wp_q, wp_d;
   logic [ADDR_WIDTH:0] rp_issue_q, rp_issue_d;
   logic [ADDR_WIDTH:0] rp_q, rp_d;
   logic                inflight_q, inflight_d;
   grant_e              last_grant_q, last_grant_d;

   logic       clr;
   logic       read_want;
   logic       write_grant;
   logic       read_grant;
   logic       out_pop;
   logic       skid_push;
   logic [1:0] skid_count;

   assign clr        = reset | flush;
   assign full       = ((wp_q - rp_issue_q) == CAPACITY);
   assign fill_count = wp_q - rp_q;
   assign empty      = (fill_count == '0);
   assign out_pop    = out_valid & out_ready;
   // A read may only be issued if its word is guaranteed a skid slot on arrival.
   assign read_want  = (rp_issue_q != wp_q) & ((3'(skid_count) + 3'(inflight_q)) < 3'd2);
   assign skid_push  = inflight_q & ~clr;
   assign mem_oe     = skid_push;

   always_comb begin
      in_ready     = 1'b0;
      write_grant  = 1'b0;
      read_grant   = 1'b0;
      last_grant_d = last_grant_q;
      if (!clr) begin
         if (read_want && last_grant_q == GRANT_WRITE) begin
            read_grant = 1'b1;
         end else begin
            in_ready    = ~full;
            write_grant = in_valid & in_ready;
            read_grant  = read_want & ~write_grant;
         end
      end
      if (write_grant)     last_grant_d = GRANT_WRITE;
      else if (read_grant) last_grant_d = GRANT_READ;

      wp_d       = wp_q + (ADDR_WIDTH+1)'(write_grant);
      rp_issue_d = rp_issue_q + (ADDR_WIDTH+1)'(read_grant);
      rp_d       = rp_q + (ADDR_WIDTH+1)'(out_pop);
      inflight_d = read_grant;
      if (flush) begin
         wp_d       = '0;
         rp_issue_d = '0;
         rp_d       = '0;
         inflight_d = 1'b0;
      end

      mem_we   = write_grant;
      mem_addr = '0;
      mem_din  = '0;
      if (write_grant) begin
         mem_addr = wp_q[ADDR_WIDTH-1:0];
         mem_din  = in_data;
      end else if (read_grant) begin
         mem_addr = rp_issue_q[ADDR_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wp_q         <= '0;
         rp_issue_q   <= '0;
         rp_q         <= '0;
         inflight_q   <= 1'b0;
         last_grant_q <= GRANT_READ;
      end else begin
         wp_q         <= wp_d;
         rp_issue_q   <= rp_issue_d;
         rp_q         <= rp_d;
         inflight_q   <= inflight_d;
         last_grant_q <= last_grant_d;
      end
   end

   bram_ring_skid #(.DW(DATA_WIDTH)) u_skid (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .push       (skid_push),
      .push_data  (mem_dout),
      .pop        (out_pop),
      .head_data  (out_data),
      .head_valid (out_valid),
      .count      (skid_count)
   );
endmodule

// File: tb/tb_bram_ring_ctrl.sv
// Scoreboard bench for bram_ring_ctrl with a 16-word memory so wrap and full are reachable.
module tb_bram_ring_ctrl;
   localparam int AW = 4;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] in_data, out_data, mem_din, mem_dout;
   logic [AW:0]   fill_count;
   logic          empty, full, mem_we, mem_oe;
   logic [AW-1:0] mem_addr;

   always #5 clk = ~clk;

   bram_ring_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .fill_count(fill_count), .empty(empty), .full(full),
      .mem_we(mem_we), .mem_oe(mem_oe), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout)
   );

   bram_8m_16 #(.AW(AW), .DW(DW)) u_mem (
      .clk(clk), .reset(reset), .we(mem_we), .oe(mem_oe),
      .addr(mem_addr), .din(mem_din), .dout(mem_dout)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   int            cyc = 0;
   logic [DW-1:0] sb_q [$];
   int            we_full_err = 0;
   logic          alt_en = 1'b0, alt_started = 1'b0, alt_prev = 1'b0;
   int            alt_err = 0;
   logic          saw_wrap = 1'b0;
   int            prev_waddr = -1;
   logic          t1_en = 1'b0;
   int            acc_edge = -1, first_ov = -1;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard and protocol monitor, sampled mid-cycle.
   always @(negedge clk) begin
      logic [DW-1:0] exp_w;
      if (out_valid && out_ready) begin
         if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
         else begin
            exp_w = sb_q.pop_front();
            chk("out_data", 32'(out_data), 32'(exp_w));
         end
      end
      if (reset || flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(in_data);
      if (full && mem_we) we_full_err++;
      if (alt_en && in_valid) begin
         if (alt_started && mem_we == alt_prev) alt_err++;
         alt_prev    = mem_we;
         alt_started = 1'b1;
      end
      if (mem_we) begin
         if (prev_waddr == 15 && mem_addr == 4'd0) saw_wrap = 1'b1;
         prev_waddr = int'(mem_addr);
      end
      if (t1_en) begin
         if (acc_edge < 0 && in_valid && in_ready) acc_edge = cyc + 1;
         if (first_ov < 0 && out_valid) first_ov = cyc;
      end
   end

   // mode: 0 out_ready high, 1 random, 2 low. Producer holds a word until accepted.
   task automatic stream(input int first, input int n, input logic [DW-1:0] base,
                         input logic [DW-1:0] stride, input int mode, input int budget,
                         output int sent);
      int   c;
      logic xfer;
      c         = 0;
      sent      = first;
      in_valid  = 1'b1;
      in_data   = base + DW'(first) * stride;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      while (sent < first + n && c < budget) begin
         @(negedge clk);
         xfer = in_valid & in_ready;
         @(posedge clk); #1;
         c++;
         if (xfer) begin
            sent++;
            if (sent < first + n) in_data = base + DW'(sent) * stride;
         end
         out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (sent == first + n) in_valid = 1'b0;
   endtask

   task automatic drain(input string tag, input int budget);
      int c;
      c         = 0;
      out_ready = 1'b1;
      while ((sb_q.size() != 0 || out_valid) && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
      chk(tag, 32'(c < budget), 32'd1);
   endtask

   task automatic apply_reset();
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int sent, c;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_fill", 32'(fill_count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_oe", 32'(mem_oe), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_din", 32'(mem_din), 0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", 32'(in_ready), 1);

      // 1: three words, latency from first accept to first out_valid
      t1_en = 1'b1;
      stream(0, 3, 16'h1111, 16'h1111, 0, 40, sent);
      chk("t1_sent", 32'(sent), 3);
      drain("t1_drain", 40);
      t1_en = 1'b0;
      chk("t1_latency", 32'(first_ov - acc_edge), 2);
      chk("t1_fill", 32'(fill_count), 0);
      chk("t1_empty", 32'(empty), 1);

      // 2: continuous stream, grants must alternate
      alt_en = 1'b1;
      stream(0, 100, 16'h0A00, 16'h0107, 0, 400, sent);
      alt_en = 1'b0;
      chk("t2_sent", 32'(sent), 100);
      chk("t2_alternate", 32'(alt_err), 0);
      drain("t2_drain", 40);

      // 3: fill with consumer stalled
      apply_reset();
      stream(0, 20, 16'h3000, 16'h0011, 2, 60, sent);
      chk("t3_accepted", 32'(sent), 18);
      chk("t3_full", 32'(full), 1);
      chk("t3_in_ready", 32'(in_ready), 0);
      chk("t3_fill", 32'(fill_count), 18);
      chk("t3_out_valid", 32'(out_valid), 1);
      stream(18, 2, 16'h3000, 16'h0011, 0, 60, sent);
      chk("t3_rest_sent", 32'(sent), 20);
      drain("t3_drain", 80);
      chk("t3_we_while_full", 32'(we_full_err), 0);

      // 4: random consumer across pointer wrap
      saw_wrap = 1'b0;
      stream(0, 40, 16'h4400, 16'h0203, 1, 400, sent);
      chk("t4_sent", 32'(sent), 40);
      drain("t4_drain", 200);
      chk("t4_wrap", 32'(saw_wrap), 1);

      // 5: flush during the capture cycle of a read
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 16'h1234;
      @(negedge clk);
      chk("t5_in_ready", 32'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("t5_out_valid", 32'(out_valid), 0);
      chk("t5_fill", 32'(fill_count), 0);
      chk("t5_empty", 32'(empty), 1);
      repeat (3) begin
         @(posedge clk); #1;
         chk("t5_discarded", 32'(out_valid), 0);
      end
      stream(0, 1, 16'hBEEF, 16'h0000, 2, 20, sent);
      c = 0;
      while (!out_valid && c < 20) begin @(posedge clk); #1; c++; end
      chk("t5_first_out", 32'(out_data), 32'hBEEF);
      drain("t5_drain", 20);

      // 6: reset with skid full
      stream(0, 5, 16'h6600, 16'h0101, 2, 40, sent);
      repeat (6) @(posedge clk);
      #1;
      chk("t6_pre_valid", 32'(out_valid), 1);
      chk("t6_pre_fill", 32'(fill_count), 5);
      reset = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD;
      @(negedge clk);
      chk("t6_we_in_reset", 32'(mem_we), 0);
      chk("t6_ready_in_reset", 32'(in_ready), 0);
      @(posedge clk); #1;
      chk("t6_out_valid", 32'(out_valid), 0);
      chk("t6_out_data", 32'(out_data), 0);
      chk("t6_fill", 32'(fill_count), 0);
      chk("t6_empty", 32'(empty), 1);
      chk("t6_mem_oe", 32'(mem_oe), 0);
      reset = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      chk("t6_post_ready", 32'(in_ready), 1);
      stream(0, 3, 16'h7700, 16'h0013, 0, 40, sent);
      chk("t6_resume_sent", 32'(sent), 3);
      drain("t6_drain", 40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1);
   end
endmodule
